// File: rtl/sc_regbank_wr_arbiter.sv
// Round-robin write arbiter for the general register bank: grants one requester,
// latches its address/data, then pulses one register write-enable and acks the winner.
module sc_regbank_wr_arbiter #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int NUM_REQ       = 4,
  parameter int NUM_REGS      = 8,
  parameter int ADDR_W        = 3
) (
  input  logic                             SC_RegGENERAL_CLOCK_50,
  input  logic                             SC_RegGENERAL_Reset_InHigh,
  input  logic                             Enable_InHigh,
  input  logic [NUM_REQ-1:0]               Req_In,
  input  logic [NUM_REQ*ADDR_W-1:0]        Addr_In,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0] Data_In,
  output logic [NUM_REQ-1:0]               Grant_Out,
  output logic [NUM_REQ-1:0]               Ack_Out,
  output logic                             Err_Out,
  output logic [DATAWIDTH_BUS-1:0]         DataBUS_Out,
  output logic [NUM_REGS-1:0]              Write_Out,
  output logic                             Busy_Out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t                   state, stateNext;
  logic [PTR_W-1:0]         pointer, winner, winnerNext;
  logic                     winnerFound;
  logic [ADDR_W-1:0]        addrLatched;
  logic [DATAWIDTH_BUS-1:0] dataLatched;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REGS-1:0]      writeVec;
  logic [ADDR_W-1:0]        addrArr [NUM_REQ];
  logic [DATAWIDTH_BUS-1:0] dataArr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign addrArr[g] = Addr_In[g*ADDR_W +: ADDR_W];
    assign dataArr[g] = Data_In[g*DATAWIDTH_BUS +: DATAWIDTH_BUS];
  end

  // Search upward from the pointer, wrapping at NUM_REQ-1, for the first active request.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    int idx;
    logic [PTR_W-1:0] idxP;
    winnerNext  = pointer;
    winnerFound = 1'b0;
    idx         = 0;
    idxP        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(pointer) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idxP = PTR_W'(idx);
      if (!winnerFound && Req_In[idxP]) begin
        winnerNext  = idxP;
        winnerFound = 1'b1;
      end
    end
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (SC_RegGENERAL_Reset_InHigh) state <= IDLE;
    else                            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Enable_InHigh && winnerFound) stateNext = GRANT;
      GRANT:   stateNext = WRITE;
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Latches are loaded only on a new grant, so requester changes after grant are ignored.
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      pointer     <= '0;
      winner      <= '0;
      grant       <= '0;
      addrLatched <= '0;
      dataLatched <= '0;
    end else if (state == IDLE && stateNext == GRANT) begin
      winner      <= winnerNext;
      grant       <= NUM_REQ'(1) << winnerNext;
      addrLatched <= addrArr[winnerNext];
      dataLatched <= dataArr[winnerNext];
    end else if (state == WRITE) begin
      grant   <= '0;
      pointer <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    writeVec = '0;
    Ack_Out  = '0;
    Err_Out  = 1'b0;
    if (state == WRITE) begin
      for (int r = 0; r < NUM_REGS; r++) writeVec[r] = (addrLatched == ADDR_W'(r));
      for (int q = 0; q < NUM_REQ; q++)  Ack_Out[q]  = (winner == PTR_W'(q));
      Err_Out = (writeVec == '0);
    end
  end

  assign Write_Out   = writeVec;
  assign Grant_Out   = grant;
  assign DataBUS_Out = dataLatched;
  assign Busy_Out    = (state != IDLE);

endmodule

// File: tb/tb_sc_regbank_wr_arbiter.sv
// Self-checking bench for sc_regbank_wr_arbiter: a scoreboard of expected write
// cycles is filled by each test and drained by a negedge monitor.
module tb_sc_regbank_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NG = 6;
  localparam int AW = 3;

  typedef struct {
    logic [NR-1:0] ack;
    logic [NG-1:0] wr;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] data = '0;
  logic [NR-1:0]    grantO, ackO;
  logic             errO, busyO;
  logic [DW-1:0]    busO;
  logic [NG-1:0]    writeO;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sc_regbank_wr_arbiter #(.DATAWIDTH_BUS(DW), .NUM_REQ(NR), .NUM_REGS(NG), .ADDR_W(AW)) dut (
    .SC_RegGENERAL_CLOCK_50    (clk),
    .SC_RegGENERAL_Reset_InHigh(rst),
    .Enable_InHigh             (en),
    .Req_In                    (req),
    .Addr_In                   (addr),
    .Data_In                   (data),
    .Grant_Out                 (grantO),
    .Ack_Out                   (ackO),
    .Err_Out                   (errO),
    .DataBUS_Out               (busO),
    .Write_Out                 (writeO),
    .Busy_Out                  (busyO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: invariants every cycle, scoreboard compare on every write cycle.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grantO) || !$onehot0(ackO) || !$onehot0(writeO) || (writeO != 0 && !busyO)) begin
      errors++;
      $display("FAIL invariant: grant=%b ack=%b write=%b busy=%b", grantO, ackO, writeO, busyO);
    end
    if (ackO != 0 || writeO != 0 || errO) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: ack=%b write=%b err=%b", ackO, writeO, errO);
      end else begin
        e = sb.pop_front();
        if ({ackO, writeO, errO, busO, grantO} !== {e.ack, e.wr, e.err, e.data, e.ack}) begin
          errors++;
          $display("FAIL write_cycle: got ack=%b write=%b err=%b bus=%h grant=%b, expected ack=%b write=%b err=%b bus=%h grant=%b",
                   ackO, writeO, errO, busO, grantO, e.ack, e.wr, e.err, e.data, e.ack);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [NR-1:0] a, input logic [NG-1:0] w, input logic er, input logic [DW-1:0] d);
    exp_t x;
    x.ack = a; x.wr = w; x.err = er; x.data = d;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int t = 0; t < max_cycles && !done; t++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !busyO) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%b, expected pending=0 busy=0", sb.size(), busyO);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({grantO, ackO, writeO, errO, busO, busyO} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b ack=%b write=%b err=%b bus=%h busy=%b, expected all 0",
               grantO, ackO, writeO, errO, busO, busyO);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    en = 1'b1;
    set_req(1, 3'd5, 32'hA5A5_0001);
    push(4'b0010, 6'b10_0000, 1'b0, 32'hA5A5_0001);
    req = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if ({grantO, busyO, writeO, busO} !== {4'b0010, 1'b1, 6'b0, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b write=%b bus=%h, expected 0010 1 000000 a5a50001",
               grantO, busyO, writeO, busO);
    end
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    checks++;
    if ({busyO, grantO} !== 5'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_return_idle: busy=%b grant=%b pending=%0d, expected 0 0000 0", busyO, grantO, sb.size());
    end
  endtask

  task automatic test_round_robin;
    int   last;
    logic got;
    test_reset();
    en = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, AW'(i), 32'hC0DE_0000 + DW'(i));
    for (int n = 0; n < 5; n++)
      push(NR'(1) << (n % NR), NG'(1) << (n % NR), 1'b0, 32'hC0DE_0000 + DW'(n % NR));
    req  = 4'b1111;
    last = 0;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        if (ackO != 0) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rr_ack_timeout: transfer %0d, no ack within 10 cycles", n);
      end else if (n > 0 && cyc - last != 3) begin
        errors++;
        $display("FAIL rr_spacing: transfer %0d spacing=%0d, expected 3", n, cyc - last);
      end
      last = cyc;
    end
    req = '0;
    wait_drain(10);
  endtask

  task automatic test_error_latch;
    set_req(0, 3'd6, 32'h1234_5678);
    push(4'b0001, 6'b0, 1'b1, 32'h1234_5678);
    req = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (grantO !== 4'b0001) begin
      errors++;
      $display("FAIL err_grant: grant=%b, expected 0001", grantO);
    end
    set_req(0, 3'd0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    checks++;
    if (busO !== 32'h1234_5678) begin
      errors++;
      $display("FAIL latched_data: bus=%h, expected 12345678", busO);
    end
    req = '0;
    wait_drain(5);
    checks++;
    if (busO !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bus_hold_idle: bus=%h, expected 12345678", busO);
    end
  endtask

  task automatic test_enable;
    en  = 1'b0;
    req = 4'b1111;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (busyO || grantO != 0) begin
        errors++;
        $display("FAIL disabled_grant: busy=%b grant=%b, expected 0 0000", busyO, grantO);
      end
    end
    set_req(2, 3'd3, 32'hCAFE_0002);
    push(4'b0100, 6'b00_1000, 1'b0, 32'hCAFE_0002);
    req = 4'b0100;
    en  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (grantO !== 4'b0100) begin
      errors++;
      $display("FAIL enable_grant: grant=%b, expected 0100", grantO);
    end
    en = 1'b0;
    wait_drain(5);
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (busyO || grantO != 0) begin
        errors++;
        $display("FAIL enable_drop_regrant: busy=%b grant=%b, expected 0 0000", busyO, grantO);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid;
    en = 1'b1;
    set_req(0, 3'd1, 32'h1111_0000);
    req = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (grantO !== 4'b0001) begin
      errors++;
      $display("FAIL mid_pre_grant: grant=%b, expected 0001", grantO);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({grantO, ackO, writeO, errO, busO, busyO} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: grant=%b ack=%b write=%b err=%b bus=%h busy=%b, expected all 0",
               grantO, ackO, writeO, errO, busO, busyO);
    end
    req = 4'b1000;
    set_req(3, 3'd4, 32'h3333_0003);
    push(4'b1000, 6'b01_0000, 1'b0, 32'h3333_0003);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (grantO !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_grant: grant=%b, expected 1000", grantO);
    end
    wait_drain(6);
    set_req(0, 3'd2, 32'h4444_0000);
    push(4'b0001, 6'b00_0100, 1'b0, 32'h4444_0000);
    req = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (grantO !== 4'b0001) begin
      errors++;
      $display("FAIL pointer_wrap: grant=%b, expected 0001", grantO);
    end
    req = '0;
    wait_drain(6);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_error_latch();
    test_enable();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
